// File: rtl/mmcm_drp_sequencer.sv
// mmcm_drp_sequencer
// Runtime clock-profile controller for the system MMCM. On request it holds the
// MMCM in reset, rewrites a table of DRP registers by read-modify-write, releases
// reset and waits for lock before reporting done. It runs on the free-running
// reference clock, never on an MMCM output.
//
// Table entry i of a profile sits at bits [39*i+38:39*i] as
// {addr[6:0], mask[15:0], data[15:0]}; a mask bit of 1 keeps the existing bit.
//
// Optional build macro: DRP_READBACK_VERIFY_EN
//   defined   -> every write is followed by a read of the same address and a
//                mismatch aborts the sequence with err set
//   undefined -> writes are not checked

module mmcm_drp_sequencer #(
    parameter int                     NUM_REGS     = 6,
    parameter logic [NUM_REGS*39-1:0] PROF0_TABLE  = '0,
    parameter logic [NUM_REGS*39-1:0] PROF1_TABLE  = '0,
    parameter int                     RST_CYCLES   = 8,
    parameter int                     DRDY_TIMEOUT = 64,
    parameter int                     LOCK_TIMEOUT = 1048576
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        sel,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic        cur_profile,
    output logic        mmcm_rst,
    input  logic        mmcm_locked,
    output logic [6:0]  drp_addr,
    output logic        drp_en,
    output logic        drp_we,
    output logic [15:0] drp_di,
    input  logic [15:0] drp_do,
    input  logic        drp_rdy
);

    localparam int IDX_W  = $clog2(NUM_REGS) + 1;
    localparam int RST_W  = (RST_CYCLES   > 1) ? $clog2(RST_CYCLES)   : 1;
    localparam int DRDY_W = (DRDY_TIMEOUT > 1) ? $clog2(DRDY_TIMEOUT) : 1;
    localparam int LOCK_W = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT) : 1;

    // Terminal counts: each counter starts at zero on entry to its state, so the
    // last value before leaving is the limit minus one.
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_REGS - 1);
    localparam logic [IDX_W-1:0]  IDX_ONE   = IDX_W'(1);
    localparam logic [RST_W-1:0]  RST_LAST  = RST_W'(RST_CYCLES - 1);
    localparam logic [RST_W-1:0]  RST_ONE   = RST_W'(1);
    localparam logic [DRDY_W-1:0] DRDY_LAST = DRDY_W'(DRDY_TIMEOUT - 1);
    localparam logic [DRDY_W-1:0] DRDY_ONE  = DRDY_W'(1);
    localparam logic [LOCK_W-1:0] LOCK_LAST = LOCK_W'(LOCK_TIMEOUT - 1);
    localparam logic [LOCK_W-1:0] LOCK_ONE  = LOCK_W'(1);

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_RST_HOLD  = 4'd1,
        ST_RD_REQ    = 4'd2,
        ST_RD_WAIT   = 4'd3,
        ST_WR_REQ    = 4'd4,
        ST_WR_WAIT   = 4'd5,
        ST_RELEASE   = 4'd6,
`ifdef DRP_READBACK_VERIFY_EN
        ST_LOCK_WAIT = 4'd7,
        ST_VFY_REQ   = 4'd8,
        ST_VFY_WAIT  = 4'd9
`else
        ST_LOCK_WAIT = 4'd7
`endif
    } state_t;

    state_t              state_q,    state_d;
    logic [IDX_W-1:0]    idx_q,      idx_d;
    logic [RST_W-1:0]    rst_cnt_q,  rst_cnt_d;
    logic [DRDY_W-1:0]   drdy_cnt_q, drdy_cnt_d;
    logic [LOCK_W-1:0]   lock_cnt_q, lock_cnt_d;
    logic                sel_q,      sel_d;
    logic                busy_q,     busy_d;
    logic                done_q,     done_d;
    logic                err_q,      err_d;
    logic                cur_q,      cur_d;
    logic                mmcm_rst_q, mmcm_rst_d;
    logic                drp_en_q,   drp_en_d;
    logic                drp_we_q,   drp_we_d;
    logic [6:0]          drp_addr_q, drp_addr_d;
    logic [15:0]         drp_di_q,   drp_di_d;
    logic                lock_meta_q;
    logic                lock_sync_q;

    logic [38:0]         cur_ent_s;
    logic [6:0]          next_addr_s;
    logic [15:0]         rmw_val_s;

    // Fetch one table entry of the selected profile; out-of-range indices read zero.
    function automatic logic [38:0] entry_f(input logic prof, input logic [IDX_W-1:0] idx);
        logic [38:0] ent;
        int          base;
        base = 39 * int'(idx);
        if (int'(idx) < NUM_REGS) begin
            if (prof) begin
                ent = PROF1_TABLE[base +: 39];
            end else begin
                ent = PROF0_TABLE[base +: 39];
            end
        end else begin
            ent = 39'd0;
        end
        return ent;
    endfunction

    // DRP address field of a table entry.
    function automatic logic [6:0] addr_f(input logic prof, input logic [IDX_W-1:0] idx);
        logic [38:0] ent;
        ent = entry_f(prof, idx);
        return ent[38:32];
    endfunction

    assign cur_ent_s   = entry_f(sel_q, idx_q);
    assign next_addr_s = addr_f(sel_q, idx_q + IDX_ONE);
    // Mask bit 1 keeps the bit read back from the MMCM, 0 takes the table data.
    assign rmw_val_s   = (drp_do & cur_ent_s[31:16]) | (cur_ent_s[15:0] & ~cur_ent_s[31:16]);

    // Next-state and registered-output logic of the sequencer.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        rst_cnt_d  = rst_cnt_q;
        drdy_cnt_d = drdy_cnt_q;
        lock_cnt_d = lock_cnt_q;
        sel_d      = sel_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        err_d      = err_q;
        cur_d      = cur_q;
        mmcm_rst_d = mmcm_rst_q;
        drp_en_d   = 1'b0;
        drp_we_d   = 1'b0;
        drp_addr_d = drp_addr_q;
        drp_di_d   = drp_di_q;

        case (state_q)
            ST_IDLE: begin
                mmcm_rst_d = 1'b0;
                if (req) begin
                    err_d = 1'b0;
                    if ((sel != cur_q) || !lock_sync_q) begin
                        state_d    = ST_RST_HOLD;
                        busy_d     = 1'b1;
                        sel_d      = sel;
                        mmcm_rst_d = 1'b1;
                        rst_cnt_d  = '0;
                        idx_d      = '0;
                    end else begin
                        // Requested profile already running and locked.
                        done_d = 1'b1;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_RST_HOLD: begin
                if (rst_cnt_q == RST_LAST) begin
                    state_d    = ST_RD_REQ;
                    drp_en_d   = 1'b1;
                    drp_addr_d = cur_ent_s[38:32];
                end else begin
                    rst_cnt_d = rst_cnt_q + RST_ONE;
                end
            end

            ST_RD_REQ: begin
                state_d    = ST_RD_WAIT;
                drdy_cnt_d = '0;
            end

            ST_RD_WAIT: begin
                if (drp_rdy) begin
                    state_d  = ST_WR_REQ;
                    drp_en_d = 1'b1;
                    drp_we_d = 1'b1;
                    drp_di_d = rmw_val_s;
                end else if (drdy_cnt_q == DRDY_LAST) begin
                    err_d      = 1'b1;
                    state_d    = ST_RELEASE;
                    mmcm_rst_d = 1'b0;
                end else begin
                    drdy_cnt_d = drdy_cnt_q + DRDY_ONE;
                end
            end

            ST_WR_REQ: begin
                state_d    = ST_WR_WAIT;
                drdy_cnt_d = '0;
            end

            ST_WR_WAIT: begin
                if (drp_rdy) begin
`ifdef DRP_READBACK_VERIFY_EN
                    state_d  = ST_VFY_REQ;
                    drp_en_d = 1'b1;
`else
                    if (idx_q == IDX_LAST) begin
                        state_d    = ST_RELEASE;
                        mmcm_rst_d = 1'b0;
                    end else begin
                        idx_d      = idx_q + IDX_ONE;
                        state_d    = ST_RD_REQ;
                        drp_en_d   = 1'b1;
                        drp_addr_d = next_addr_s;
                    end
`endif
                end else if (drdy_cnt_q == DRDY_LAST) begin
                    err_d      = 1'b1;
                    state_d    = ST_RELEASE;
                    mmcm_rst_d = 1'b0;
                end else begin
                    drdy_cnt_d = drdy_cnt_q + DRDY_ONE;
                end
            end

`ifdef DRP_READBACK_VERIFY_EN
            ST_VFY_REQ: begin
                state_d    = ST_VFY_WAIT;
                drdy_cnt_d = '0;
            end

            ST_VFY_WAIT: begin
                if (drp_rdy) begin
                    if (drp_do != drp_di_q) begin
                        err_d      = 1'b1;
                        state_d    = ST_RELEASE;
                        mmcm_rst_d = 1'b0;
                    end else if (idx_q == IDX_LAST) begin
                        state_d    = ST_RELEASE;
                        mmcm_rst_d = 1'b0;
                    end else begin
                        idx_d      = idx_q + IDX_ONE;
                        state_d    = ST_RD_REQ;
                        drp_en_d   = 1'b1;
                        drp_addr_d = next_addr_s;
                    end
                end else if (drdy_cnt_q == DRDY_LAST) begin
                    err_d      = 1'b1;
                    state_d    = ST_RELEASE;
                    mmcm_rst_d = 1'b0;
                end else begin
                    drdy_cnt_d = drdy_cnt_q + DRDY_ONE;
                end
            end
`endif

            ST_RELEASE: begin
                mmcm_rst_d = 1'b0;
                lock_cnt_d = '0;
                state_d    = ST_LOCK_WAIT;
            end

            ST_LOCK_WAIT: begin
                mmcm_rst_d = 1'b0;
                if (lock_sync_q) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                    if (!err_q) begin
                        done_d = 1'b1;
                        cur_d  = sel_q;
                    end else begin
                        // Aborted sequence: the profile is not claimed as loaded.
                        cur_d = cur_q;
                    end
                end else if (lock_cnt_q == LOCK_LAST) begin
                    err_d   = 1'b1;
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end else begin
                    lock_cnt_d = lock_cnt_q + LOCK_ONE;
                end
            end

            default: begin
                state_d    = ST_IDLE;
                busy_d     = 1'b0;
                mmcm_rst_d = 1'b0;
            end
        endcase
    end

    // State and output registers; rst returns everything to idle with the MMCM held in reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            idx_q      <= '0;
            rst_cnt_q  <= '0;
            drdy_cnt_q <= '0;
            lock_cnt_q <= '0;
            sel_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            cur_q      <= 1'b0;
            mmcm_rst_q <= 1'b1;
            drp_en_q   <= 1'b0;
            drp_we_q   <= 1'b0;
            drp_addr_q <= 7'd0;
            drp_di_q   <= 16'd0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            rst_cnt_q  <= rst_cnt_d;
            drdy_cnt_q <= drdy_cnt_d;
            lock_cnt_q <= lock_cnt_d;
            sel_q      <= sel_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
            cur_q      <= cur_d;
            mmcm_rst_q <= mmcm_rst_d;
            drp_en_q   <= drp_en_d;
            drp_we_q   <= drp_we_d;
            drp_addr_q <= drp_addr_d;
            drp_di_q   <= drp_di_d;
        end
    end

    // Two-flop synchroniser for the asynchronous MMCM LOCKED output.
    always_ff @(posedge clk) begin
        if (rst) begin
            lock_meta_q <= 1'b0;
            lock_sync_q <= 1'b0;
        end else begin
            lock_meta_q <= mmcm_locked;
            lock_sync_q <= lock_meta_q;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign err         = err_q;
    assign cur_profile = cur_q;
    assign mmcm_rst    = mmcm_rst_q;
    assign drp_en      = drp_en_q;
    assign drp_we      = drp_we_q;
    assign drp_addr    = drp_addr_q;
    assign drp_di      = drp_di_q;

endmodule

// File: tb/tb_mmcm_drp_sequencer.sv
// Directed self-checking bench for mmcm_drp_sequencer with a two-entry table,
// a behavioural DRP port (DRDY three cycles after DEN, reads 0xFFFF until written)
// and an MMCM lock model (LOCKED twenty cycles after reset release).
module tb_mmcm_drp_sequencer;

    localparam logic [77:0] P1_TABLE = {7'h14, 16'h1000, 16'h0514,
                                        7'h08, 16'h1000, 16'h0145};

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req = 1'b0;
    logic        sel = 1'b0;
    logic        busy, done, err, cur_profile, mmcm_rst;
    logic        mmcm_locked = 1'b0;
    logic [6:0]  drp_addr;
    logic        drp_en, drp_we;
    logic [15:0] drp_di;
    logic [15:0] drp_do = 16'h0000;
    logic        drp_rdy = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;

    // DRP / lock model state
    logic [15:0] mem [0:127];
    bit          written [0:127];
    logic [6:0]  wr_addr_log [0:15];
    logic [15:0] wr_data_log [0:15];
    int          wr_cnt      = 0;
    int          dly         = 0;
    int          lk_cnt      = 0;
    logic [6:0]  pend_addr   = 7'd0;
    bit          pend_we     = 1'b0;
    bit          no_rdy      = 1'b0;
    bit          corrupt     = 1'b0;
    bit          lock_enable = 1'b1;

    mmcm_drp_sequencer #(
        .NUM_REGS     (2),
        .PROF0_TABLE  (78'd0),
        .PROF1_TABLE  (P1_TABLE),
        .RST_CYCLES   (8),
        .DRDY_TIMEOUT (64),
        .LOCK_TIMEOUT (100)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .sel         (sel),
        .busy        (busy),
        .done        (done),
        .err         (err),
        .cur_profile (cur_profile),
        .mmcm_rst    (mmcm_rst),
        .mmcm_locked (mmcm_locked),
        .drp_addr    (drp_addr),
        .drp_en      (drp_en),
        .drp_we      (drp_we),
        .drp_di      (drp_di),
        .drp_do      (drp_do),
        .drp_rdy     (drp_rdy)
    );

    always #5 clk = ~clk;

    // Behavioural DRP port and MMCM lock, updated away from the active edge.
    always @(negedge clk) begin
        drp_rdy = 1'b0;
        if (drp_en) begin
            if (drp_we) begin
                mem[drp_addr]     = drp_di;
                written[drp_addr] = 1'b1;
                if (wr_cnt < 16) begin
                    wr_addr_log[wr_cnt] = drp_addr;
                    wr_data_log[wr_cnt] = drp_di;
                end
                wr_cnt++;
            end
            pend_addr = drp_addr;
            pend_we   = drp_we;
            dly       = no_rdy ? 0 : 3;
        end else if (dly > 0) begin
            dly--;
            if (dly == 0) begin
                drp_rdy = 1'b1;
                drp_do  = mem[pend_addr];
                if (corrupt && !pend_we && pend_addr == 7'h08 && written[pend_addr])
                    drp_do = drp_do ^ 16'h0001;
            end
        end
        if (mmcm_rst) begin
            lk_cnt      = 0;
            mmcm_locked = 1'b0;
        end else begin
            if (lk_cnt < 1000) lk_cnt++;
            mmcm_locked = lock_enable && (lk_cnt >= 20);
        end
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h required 0x%0h", tag, got, exp);
        end
    endtask

    // Wait (bounded) for: 0 drp_en=1, 1 err=1, 2 busy=0, 3 mmcm_rst=0, 4 done=1.
    // n = negedges waited; saw_done / rst_hi record done pulses and reset-held idle cycles.
    task automatic wait_cond(input int which, input int limit, output int n,
                             output bit saw_done, output int rst_hi);
        bit hit;
        hit = 1'b0; n = 0; saw_done = 1'b0; rst_hi = 0;
        while (!hit && n < limit) begin
            @(negedge clk);
            n++;
            if (done) saw_done = 1'b1;
            if (mmcm_rst && !drp_en) rst_hi++;
            case (which)
                0: hit = drp_en;
                1: hit = err;
                2: hit = !busy;
                3: hit = !mmcm_rst;
                4: hit = done;
                default: hit = 1'b1;
            endcase
        end
        check_val($sformatf("wait_cond%0d_reached", which), {31'd0, hit}, 32'd1);
    endtask

    task automatic pulse_req(input logic s);
        req = 1'b1;
        sel = s;
        @(negedge clk);
        req = 1'b0;
        sel = ~s;
    endtask

    initial begin
        int n, rh, act, base;
        bit sd;
        for (int i = 0; i < 128; i++) begin
            mem[i]     = 16'hFFFF;
            written[i] = 1'b0;
        end

        // Reset values
        repeat (4) @(negedge clk);
        check_val("rst_mmcm_rst", {31'd0, mmcm_rst}, 32'd1);
        check_val("rst_busy",     {31'd0, busy}, 32'd0);
        check_val("rst_done",     {31'd0, done}, 32'd0);
        check_val("rst_err",      {31'd0, err}, 32'd0);
        check_val("rst_cur",      {31'd0, cur_profile}, 32'd0);
        check_val("rst_en",       {31'd0, drp_en}, 32'd0);
        check_val("rst_we",       {31'd0, drp_we}, 32'd0);
        check_val("rst_addr",     {25'd0, drp_addr}, 32'd0);
        check_val("rst_di",       {16'd0, drp_di}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check_val("post_rst_mmcm_rst", {31'd0, mmcm_rst}, 32'd0);
        act = 0;
        repeat (100) begin
            @(negedge clk);
            if (drp_en || busy) act++;
        end
        check_val("idle_activity", act, 32'd0);

        // Same profile, locked: immediate done, no DRP, MMCM untouched
        pulse_req(1'b0);
        check_val("same_done",     {31'd0, done}, 32'd1);
        check_val("same_busy",     {31'd0, busy}, 32'd0);
        check_val("same_en",       {31'd0, drp_en}, 32'd0);
        check_val("same_mmcm_rst", {31'd0, mmcm_rst}, 32'd0);
        @(negedge clk);
        check_val("same_done_1cyc", {31'd0, done}, 32'd0);
        check_val("same_mmcm_rst2", {31'd0, mmcm_rst}, 32'd0);

        // Switch to profile 1 (sel flips back after accept to prove it was latched)
        pulse_req(1'b1);
        check_val("sw_busy",     {31'd0, busy}, 32'd1);
        check_val("sw_mmcm_rst", {31'd0, mmcm_rst}, 32'd1);
        wait_cond(0, 50, n, sd, rh);
        // one reset cycle seen before the wait plus rh seen during it
        check_val("sw_rst_hold_ge8", {31'd0, (rh + 1) >= 8}, 32'd1);
        check_val("sw_rd_addr", {25'd0, drp_addr}, 32'h08);
        check_val("sw_rd_we",   {31'd0, drp_we}, 32'd0);
        wait_cond(4, 400, n, sd, rh);
        check_val("sw_cur",     {31'd0, cur_profile}, 32'd1);
        check_val("sw_err",     {31'd0, err}, 32'd0);
        check_val("sw_busy_end",{31'd0, busy}, 32'd0);
        check_val("sw_wr_cnt",  wr_cnt, 32'd2);
        check_val("sw_wr0_addr",{25'd0, wr_addr_log[0]}, 32'h08);
        check_val("sw_wr0_data",{16'd0, wr_data_log[0]}, 32'h1145);
        check_val("sw_wr1_addr",{25'd0, wr_addr_log[1]}, 32'h14);
        check_val("sw_wr1_data",{16'd0, wr_data_log[1]}, 32'h1514);
        @(negedge clk);
        check_val("sw_done_1cyc", {31'd0, done}, 32'd0);

        // DRDY never arrives: err after RD_REQ + 64 wait cycles, then lock without done
        no_rdy = 1'b1;
        pulse_req(1'b0);
        wait_cond(0, 50, n, sd, rh);
        wait_cond(1, 200, n, sd, rh);
        check_val("to_err_latency", n, 32'd65);
        check_val("to_mmcm_rst",    {31'd0, mmcm_rst}, 32'd0);
        check_val("to_busy_held",   {31'd0, busy}, 32'd1);
        wait_cond(2, 200, n, sd, rh);
        check_val("to_no_done", {31'd0, sd}, 32'd0);
        check_val("to_cur",     {31'd0, cur_profile}, 32'd1);
        check_val("to_err",     {31'd0, err}, 32'd1);
        no_rdy = 1'b0;
        repeat (5) @(negedge clk);
        pulse_req(1'b1);
        check_val("clr_done", {31'd0, done}, 32'd1);
        check_val("clr_err",  {31'd0, err}, 32'd0);

        // Lock never comes: err exactly 100 cycles after LOCK_WAIT entry
        lock_enable = 1'b0;
        pulse_req(1'b0);
        wait_cond(0, 50, n, sd, rh);
        wait_cond(3, 200, n, sd, rh);   // first RELEASE cycle
        check_val("lk_err_before", {31'd0, err}, 32'd0);
        wait_cond(1, 300, n, sd, rh);
        // RELEASE cycle + 100 LOCK_WAIT cycles
        check_val("lk_err_latency", n, 32'd101);
        check_val("lk_no_done",  {31'd0, sd}, 32'd0);
        check_val("lk_busy",     {31'd0, busy}, 32'd0);
        check_val("lk_mmcm_rst", {31'd0, mmcm_rst}, 32'd0);
        check_val("lk_cur",      {31'd0, cur_profile}, 32'd1);

        // rst in the middle of RD_WAIT
        lock_enable = 1'b1;
        repeat (30) @(negedge clk);
        pulse_req(1'b0);
        wait_cond(0, 50, n, sd, rh);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_val("mid_en",       {31'd0, drp_en}, 32'd0);
        check_val("mid_mmcm_rst", {31'd0, mmcm_rst}, 32'd1);
        check_val("mid_busy",     {31'd0, busy}, 32'd0);
        check_val("mid_cur",      {31'd0, cur_profile}, 32'd0);
        check_val("mid_err",      {31'd0, err}, 32'd0);
        rst = 1'b0;
        act = 0;
        repeat (10) begin
            @(negedge clk);
            if (drp_en || busy || mmcm_rst) act++;
        end
        check_val("mid_quiet_after", act, 32'd0);

`ifdef DRP_READBACK_VERIFY_EN
        // Readback of entry 0 corrupted: err, entry 1 never written, no done
        corrupt = 1'b1;
        repeat (30) @(negedge clk);
        base = wr_cnt;
        pulse_req(1'b1);
        wait_cond(1, 300, n, sd, rh);
        check_val("vfy_wr_count", wr_cnt - base, 32'd1);
        check_val("vfy_wr_addr",  {25'd0, wr_addr_log[base]}, 32'h08);
        wait_cond(2, 200, n, sd, rh);
        check_val("vfy_no_done",  {31'd0, sd}, 32'd0);
        check_val("vfy_cur",      {31'd0, cur_profile}, 32'd0);
        check_val("vfy_wr_after", wr_cnt - base, 32'd1);
`else
        base = 0;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + base * 0);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
